// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC multicycle controller: state encoding,
// opcode map, addressing-mode constant and alu_op encodings.
package sisc_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam int OP_NOOP = 0;
    localparam int OP_LOD  = 1;
    localparam int OP_STR  = 2;
    localparam int OP_SWP  = 3;
    localparam int OP_BRA  = 4;
    localparam int OP_BRR  = 5;
    localparam int OP_BNE  = 6;
    localparam int OP_BNR  = 7;
    localparam int OP_ALU  = 8;
    localparam int OP_HLT  = 15;

    localparam int AM_IMM = 8;

    // bit1 suppresses the status save, bit0 selects the immediate operand
    localparam logic [1:0] ALU_REG        = 2'b00;
    localparam logic [1:0] ALU_IMM        = 2'b01;
    localparam logic [1:0] ALU_NOSAVE     = 2'b10;
    localparam logic [1:0] ALU_NOSAVE_IMM = 2'b11;

endpackage

// File: rtl/sisc_br_cond.sv
// Combinational branch evaluator: condition is |(stat & mm); BRA/BRR take on
// a set condition, BNE/BNR on a clear one. BRA/BNE are absolute targets.
module sisc_br_cond
    import sisc_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int MM_W  = 4
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [MM_W-1:0]  mm,
    input  logic [MM_W-1:0]  stat,
    output logic             taken,
    output logic             absolute
);

    logic cond;

    always_comb begin
        cond     = |(stat & mm);
        taken    = 1'b0;
        absolute = 1'b0;
        if (opcode == OPC_W'(OP_BRA)) begin
            taken    = cond;
            absolute = 1'b1;
        end else if (opcode == OPC_W'(OP_BRR)) begin
            taken = cond;
        end else if (opcode == OPC_W'(OP_BNE)) begin
            taken    = !cond;
            absolute = 1'b1;
        end else if (opcode == OPC_W'(OP_BNR)) begin
            taken = !cond;
        end
    end

endmodule

// File: rtl/sisc_ctrl_fsm.sv
// SISC multicycle control FSM with retired-instruction counter and HALT state.
// Define SISC_MEMWAIT_EN to add the mem_rdy handshake and wait-timeout.
module sisc_ctrl_fsm
    import sisc_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int MM_W     = 4,
    parameter int STAT_W   = 4,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [MM_W-1:0]   mm,
    input  logic [STAT_W-1:0] stat,
`ifdef SISC_MEMWAIT_EN
    input  logic              mem_rdy,
`endif
    output logic              rf_we,
    output logic              wb_sel,
    output logic              br_sel,
    output logic              rb_sel,
    output logic              ir_load,
    output logic              pc_sel,
    output logic              pc_write,
    output logic              pc_rst,
    output logic              mm_we,
    output logic [1:0]        alu_op,
    output logic              halted,
    output logic              illegal,
    output logic              mem_err,
    output logic [CNT_W-1:0]  retired,
    output logic [2:0]        state
);

    state_t cur, nxt;
    logic   cnt_en;
    logic   br_taken, br_abs;
    logic   is_alu, is_lod, is_str, is_hlt, is_br, is_legal, is_imm;

    sisc_br_cond #(.OPC_W(OPC_W), .MM_W(MM_W)) u_br_cond (
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .taken    (br_taken),
        .absolute (br_abs)
    );

    assign is_alu   = (opcode == OPC_W'(OP_ALU));
    assign is_lod   = (opcode == OPC_W'(OP_LOD));
    assign is_str   = (opcode == OPC_W'(OP_STR));
    assign is_hlt   = (opcode == OPC_W'(OP_HLT));
    assign is_br    = (opcode == OPC_W'(OP_BRA)) || (opcode == OPC_W'(OP_BRR)) ||
                      (opcode == OPC_W'(OP_BNE)) || (opcode == OPC_W'(OP_BNR));
    assign is_legal = is_alu || is_lod || is_str || is_hlt || is_br ||
                      (opcode == OPC_W'(OP_NOOP)) || (opcode == OPC_W'(OP_SWP));
    assign is_imm   = (mm == MM_W'(AM_IMM));
    assign state    = cur;

    always_comb begin
        nxt    = cur;
        cnt_en = 1'b0;
        case (cur)
            S_RESET:     nxt = S_FETCH;
            S_FETCH:     nxt = S_DECODE;
            S_DECODE: begin
                if (is_hlt) nxt = S_HALT;
                else if (is_alu || is_lod || is_str) nxt = S_EXECUTE;
                else begin
                    nxt    = S_FETCH;
                    cnt_en = 1'b1;
                end
            end
            S_EXECUTE:   nxt = S_MEM;
            S_MEM:       nxt = S_WRITEBACK;
            S_WRITEBACK: begin
                nxt    = S_FETCH;
                cnt_en = 1'b1;
            end
            S_HALT:      nxt = S_HALT;
            default:     nxt = S_RESET;
        endcase
    end

`ifdef SISC_MEMWAIT_EN
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    logic [WAIT_W-1:0] wcnt;
    logic              mem_stage;

    // only instruction fetch and data-memory accesses wait on memory
    assign mem_stage = (cur == S_FETCH) || ((cur == S_MEM) && (is_lod || is_str));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cur     <= S_RESET;
            retired <= '0;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else if (mem_stage && !mem_rdy) begin
            if (wcnt == WAIT_W'(WAIT_MAX - 1)) begin
                cur     <= S_HALT;
                wcnt    <= '0;
                mem_err <= 1'b1;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end else begin
            cur  <= nxt;
            wcnt <= '0;
            if (cnt_en) retired <= retired + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^WAIT_MAX;
    assign mem_err    = 1'b0;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cur     <= S_RESET;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cnt_en) retired <= retired + 1'b1;
        end
    end
`endif

    always_comb begin
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        br_sel   = 1'b0;
        rb_sel   = 1'b0;
        ir_load  = 1'b0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        mm_we    = 1'b0;
        alu_op   = ALU_NOSAVE;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (cur)
            S_RESET: pc_rst = 1'b1;
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                illegal = !is_legal;
                if (br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = br_abs;
                end
            end
            S_EXECUTE: begin
                if (is_alu) alu_op = is_imm ? ALU_IMM : ALU_REG;
                if (is_lod || is_str) alu_op = ALU_IMM;
                rb_sel = is_str;
            end
            S_MEM: begin
                if (is_alu) alu_op = is_imm ? ALU_NOSAVE_IMM : ALU_NOSAVE;
                if (is_lod || is_str) alu_op = ALU_NOSAVE_IMM;
                mm_we  = is_str;
                rb_sel = is_str;
            end
            S_WRITEBACK: begin
                rf_we  = is_alu || is_lod;
                wb_sel = is_lod;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Scoreboard bench for sisc_ctrl_fsm: the driver queues hand-computed per-cycle
// expectations, a monitor pops and compares on each falling edge or probe event.
module tb_sisc_ctrl_fsm;
    import sisc_pkg::*;

    typedef struct packed {
        logic       rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst, mm_we;
        logic [1:0] alu_op;
        logic       halted, illegal, mem_err;
    } outs_t;

    typedef struct {
        state_t      st;
        outs_t       o;
        logic [15:0] ret;
        string       nm;
    } exp_t;

    localparam int F_RF = 1, F_WB = 2, F_BR = 4, F_RB = 8, F_IR = 16, F_PCS = 32,
                   F_PCW = 64, F_PCR = 128, F_MMW = 256, F_HLT = 512, F_ILL = 1024,
                   F_ERR = 2048;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [3:0]  opcode, mm, stat;
    logic        rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst, mm_we;
    logic [1:0]  alu_op;
    logic        halted, illegal, mem_err;
    logic [15:0] retired;
    logic [2:0]  state;
`ifdef SISC_MEMWAIT_EN
    logic        mem_rdy;
`endif

    always #5 clk = ~clk;

    sisc_ctrl_fsm dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
`ifdef SISC_MEMWAIT_EN
        .mem_rdy(mem_rdy),
`endif
        .rf_we(rf_we), .wb_sel(wb_sel), .br_sel(br_sel), .rb_sel(rb_sel),
        .ir_load(ir_load), .pc_sel(pc_sel), .pc_write(pc_write), .pc_rst(pc_rst),
        .mm_we(mm_we), .alu_op(alu_op), .halted(halted), .illegal(illegal),
        .mem_err(mem_err), .retired(retired), .state(state)
    );

    exp_t  q[$];
    int    checks = 0;
    int    passed = 0;
    int    exp_ret = 0;
    event  probe;
    outs_t act;

    assign act = {rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst,
                  mm_we, alu_op, halted, illegal, mem_err};

    function automatic outs_t mk(input logic [1:0] alu, input int f);
        outs_t o;
        o.rf_we = f[0];  o.wb_sel = f[1];   o.br_sel = f[2];    o.rb_sel = f[3];
        o.ir_load = f[4]; o.pc_sel = f[5];  o.pc_write = f[6];  o.pc_rst = f[7];
        o.mm_we = f[8];  o.halted = f[9];   o.illegal = f[10];  o.mem_err = f[11];
        o.alu_op = alu;
        return o;
    endfunction

    task automatic push(input state_t s, input outs_t o, input string nm);
        exp_t e;
        e.st = s; e.o = o; e.ret = 16'(exp_ret); e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(input state_t s, input outs_t o, input string nm);
        push(s, o, nm);
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or probe);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (state == e.st && act == e.o && retired == e.ret) passed++;
                else $display("FAIL %s: got state=%0d outs=%b retired=%0d, want state=%0d outs=%b retired=%0d",
                              e.nm, state, act, retired, e.st, e.o, e.ret);
            end
        end
    end

    initial begin : driver
        outs_t rs, fe, df;
        rs = mk(2'b10, F_PCR);
        fe = mk(2'b10, F_IR | F_PCW);
        df = mk(2'b10, 0);
        rst_f = 1'b0; opcode = '0; mm = '0; stat = '0;
`ifdef SISC_MEMWAIT_EN
        mem_rdy = 1'b1;
`endif
        @(posedge clk); #1;
        step(S_RESET, rs, "reset0");
        step(S_RESET, rs, "reset1");
        rst_f = 1'b1;
        step(S_RESET, rs, "reset_release");

        opcode = 4'd8; mm = 4'd8;
        step(S_FETCH, fe, "adi_fetch");
        step(S_DECODE, df, "adi_decode");
        step(S_EXECUTE, mk(2'b01, 0), "adi_exec");
        step(S_MEM, mk(2'b11, 0), "adi_mem");
        step(S_WRITEBACK, mk(2'b10, F_RF), "adi_wb");
        exp_ret = 1;

        opcode = 4'd8; mm = 4'd0;
        step(S_FETCH, fe, "add_fetch");
        step(S_DECODE, df, "add_decode");
        step(S_EXECUTE, mk(2'b00, 0), "add_exec");
        step(S_MEM, mk(2'b10, 0), "add_mem");
        step(S_WRITEBACK, mk(2'b10, F_RF), "add_wb");
        exp_ret = 2;

        stat = 4'b0100;
        opcode = 4'd4; mm = 4'b0100;
        step(S_FETCH, fe, "bra_fetch");
        step(S_DECODE, mk(2'b10, F_PCW | F_PCS | F_BR), "bra_taken");
        exp_ret = 3;
        opcode = 4'd7; mm = 4'b0100;
        step(S_FETCH, fe, "bnr_fetch");
        step(S_DECODE, df, "bnr_not_taken");
        exp_ret = 4;
        opcode = 4'd5; mm = 4'b0001;
        step(S_FETCH, fe, "brr_fetch");
        step(S_DECODE, df, "brr_not_taken");
        exp_ret = 5;
        opcode = 4'd6; mm = 4'b0001;
        step(S_FETCH, fe, "bne_fetch");
        step(S_DECODE, mk(2'b10, F_PCW | F_PCS | F_BR), "bne_taken");
        exp_ret = 6;
        opcode = 4'd5; mm = 4'b1100;
        step(S_FETCH, fe, "brr2_fetch");
        step(S_DECODE, mk(2'b10, F_PCW | F_PCS), "brr_taken");
        exp_ret = 7;

        opcode = 4'd1; mm = 4'd3;
        step(S_FETCH, fe, "lod_fetch");
        step(S_DECODE, df, "lod_decode");
        step(S_EXECUTE, mk(2'b01, 0), "lod_exec");
        step(S_MEM, mk(2'b11, 0), "lod_mem");
        step(S_WRITEBACK, mk(2'b10, F_RF | F_WB), "lod_wb");
        exp_ret = 8;

        opcode = 4'd2; mm = 4'd3;
        step(S_FETCH, fe, "str_fetch");
        step(S_DECODE, df, "str_decode");
        step(S_EXECUTE, mk(2'b01, F_RB), "str_exec");
        step(S_MEM, mk(2'b11, F_MMW | F_RB), "str_mem");
        step(S_WRITEBACK, df, "str_wb");
        exp_ret = 9;

        opcode = 4'd0; mm = 4'd0;
        step(S_FETCH, fe, "noop_fetch");
        step(S_DECODE, df, "noop_decode");
        exp_ret = 10;
        opcode = 4'd3;
        step(S_FETCH, fe, "swp_fetch");
        step(S_DECODE, df, "swp_decode");
        exp_ret = 11;
        opcode = 4'd10;
        step(S_FETCH, fe, "ill_fetch");
        step(S_DECODE, mk(2'b10, F_ILL), "ill_decode");
        exp_ret = 12;

        opcode = 4'd8; mm = 4'd0;
        step(S_FETCH, fe, "rst_add_fetch");
        step(S_DECODE, df, "rst_add_decode");
        push(S_EXECUTE, mk(2'b00, 0), "rst_add_exec");
        #7;
        rst_f = 1'b0;
        #1;
        exp_ret = 0;
        checks++;
        if (state == S_RESET && pc_rst === 1'b1 && retired == 16'd0) passed++;
        else $display("FAIL reset_state: got state=%0d pc_rst=%b retired=%0d", state, pc_rst, retired);
        push(S_RESET, rs, "async_reset");
        -> probe;
        @(posedge clk); #1;
        step(S_RESET, rs, "reset_hold");
        rst_f = 1'b1;
        step(S_RESET, rs, "reset_release2");

        opcode = 4'd0;
        step(S_FETCH, fe, "noop2_fetch");
        step(S_DECODE, df, "noop2_decode");
        exp_ret = 1;

        opcode = 4'd15;
        step(S_FETCH, fe, "hlt_fetch");
        step(S_DECODE, df, "hlt_decode");
        for (int i = 0; i < 100; i++) step(S_HALT, mk(2'b10, F_HLT), "halt_hold");

`ifdef SISC_MEMWAIT_EN
        rst_f = 1'b0; opcode = 4'd0;
        exp_ret = 0;
        step(S_RESET, rs, "mw_reset");
        mem_rdy = 1'b0;
        rst_f = 1'b1;
        step(S_RESET, rs, "mw_release");
        for (int i = 0; i < 15; i++) step(S_FETCH, fe, "mw_fetch_hold");
        step(S_HALT, mk(2'b10, F_HLT | F_ERR), "mw_timeout");
        checks++;
        if (state == S_HALT && halted === 1'b1 && mem_err === 1'b1) passed++;
        else $display("FAIL wait_expired: got state=%0d halted=%b mem_err=%b", state, halted, mem_err);
`endif

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
